// File: rtl/regfile_mp_sb.sv
// Multi-port register file: NREAD combinational read ports, two prioritised write
// ports with enable-qualified write-through, and a per-register pending scoreboard.
module regfile_mp_sb #(
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 5,
    parameter int          NREAD   = 2,
    parameter int          SP_IDX  = 29,
    parameter logic [31:0] SP_INIT = 32'h0000fffc
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREAD*ADDR_W-1:0]   rd_addr,
    output logic [NREAD*DATA_W-1:0]   rd_data,
    output logic [NREAD-1:0]          rd_ready,
    input  logic                      we0,
    input  logic [ADDR_W-1:0]         waddr0,
    input  logic [DATA_W-1:0]         wdata0,
    input  logic                      we1,
    input  logic [ADDR_W-1:0]         waddr1,
    input  logic [DATA_W-1:0]         wdata1,
    input  logic                      pend_set,
    input  logic [ADDR_W-1:0]         pend_addr,
    input  logic                      flush,
    output logic [ADDR_W:0]           pend_cnt,
    output logic                      pend_full
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [CNT_W-1:0]  pend_cnt_q, pend_cnt_d;

    logic eff0, eff1, set_eff;
    logic set_new, clr0, clr1;

    // Index 0 is hardwired to zero, so writes and pending marks aimed at it are dropped.
    assign eff0    = we0 && (waddr0 != '0);
    assign eff1    = we1 && (waddr1 != '0);
    assign set_eff = pend_set && (pend_addr != '0);

    // Storage next-state: port 1 is applied last so it wins a same-index collision.
    always_comb begin
        regs_d = regs_q;
        if (eff0) regs_d[waddr0] = wdata0;
        if (eff1) regs_d[waddr1] = wdata1;
    end

    always_comb begin
        pend_d = pend_q;
        if (eff0)    pend_d[waddr0]    = 1'b0;
        if (eff1)    pend_d[waddr1]    = 1'b0;
        if (set_eff) pend_d[pend_addr] = 1'b1;
        if (flush)   pend_d            = '0;
    end

    // Counter deltas mirror the bit update so the count always equals popcount(pend_q);
    // a clear hidden by a same-index set, or by the other port's clear, is not counted.
    assign set_new = set_eff && !pend_q[pend_addr];
    assign clr1    = eff1 && pend_q[waddr1] && !(set_eff && (pend_addr == waddr1));
    assign clr0    = eff0 && pend_q[waddr0] && !(set_eff && (pend_addr == waddr0))
                     && !(eff1 && (waddr1 == waddr0));

    always_comb begin
        if (flush) begin
            pend_cnt_d = '0;
        end else begin
            pend_cnt_d = pend_cnt_q + CNT_W'(set_new) - CNT_W'(clr0) - CNT_W'(clr1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the register array is architectural state (SP has a defined reset
            // value), so every entry is reset rather than left to power-up contents.
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;
            end
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            regs_q     <= regs_d;
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pend_cnt  = pend_cnt_q;
    assign pend_full = (pend_cnt_q == CNT_W'(DEPTH - 1));

    // Read ports: forwarding requires an effective write, never an address match alone.
    logic [ADDR_W-1:0] ra;
    always_comb begin
        // NOTE: defaults before the loop keep these purely combinational (no latches).
        rd_data  = '0;
        rd_ready = '0;
        ra       = '0;
        for (int i = 0; i < NREAD; i++) begin
            ra = rd_addr[i*ADDR_W +: ADDR_W];
            if (ra == '0) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
                rd_ready[i]                 = 1'b1;
            end else if (eff1 && (waddr1 == ra)) begin
                rd_data[i*DATA_W +: DATA_W] = wdata1;
                rd_ready[i]                 = 1'b1;
            end else if (eff0 && (waddr0 == ra)) begin
                rd_data[i*DATA_W +: DATA_W] = wdata0;
                rd_ready[i]                 = 1'b1;
            end else begin
                rd_data[i*DATA_W +: DATA_W] = regs_q[ra];
                rd_ready[i]                 = !pend_q[ra];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench for regfile_mp_sb: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_regfile_mp_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_ready;
    logic              we0, we1, pend_set, flush;
    logic [AW-1:0]     waddr0, waddr1, pend_addr;
    logic [DW-1:0]     wdata0, wdata1;
    logic [AW:0]       pend_cnt;
    logic              pend_full;

    regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .pend_set(pend_set), .pend_addr(pend_addr), .flush(flush),
        .pend_cnt(pend_cnt), .pend_full(pend_full)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_cnt;
        logic        port;
        logic [31:0] data;
        logic        flag;
        logic [5:0]  cnt;
    } exp_t;

    exp_t  sb_q[$];
    string name_q[$];
    int    n_pass  = 0;
    int    n_total = 0;

    task automatic push_rd(input int p, input logic [31:0] d, input logic rdy, input string nm);
        exp_t e;
        e        = '0;
        e.port   = (p != 0);
        e.data   = d;
        e.flag   = rdy;
        sb_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic push_cnt(input logic [5:0] c, input logic full, input string nm);
        exp_t e;
        e        = '0;
        e.is_cnt = 1'b1;
        e.cnt    = c;
        e.flag   = full;
        sb_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: everything queued during a cycle is checked at that cycle's falling edge.
    exp_t        mon_e;
    string       mon_nm;
    int          mon_p;
    logic [31:0] act_d;
    logic        act_r;
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_e  = sb_q.pop_front();
            mon_nm = name_q.pop_front();
            n_total++;
            if (!mon_e.is_cnt) begin
                mon_p = int'(mon_e.port);
                act_d = rd_data[mon_p*DW +: DW];
                act_r = rd_ready[mon_p];
                if (act_d === mon_e.data && act_r === mon_e.flag) n_pass++;
                else $display("FAIL %s: port%0d got data=%h ready=%b, want data=%h ready=%b",
                              mon_nm, mon_p, act_d, act_r, mon_e.data, mon_e.flag);
            end else begin
                if (pend_cnt === mon_e.cnt && pend_full === mon_e.flag) n_pass++;
                else $display("FAIL %s: got pend_cnt=%0d pend_full=%b, want pend_cnt=%0d pend_full=%b",
                              mon_nm, pend_cnt, pend_full, mon_e.cnt, mon_e.flag);
            end
        end
    end

    task automatic idle_inputs();
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        pend_set = 1'b0; pend_addr = '0; flush = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rd_addr = '0;
        idle_inputs();
        @(posedge clk);

        // Reset state
        step(); reset = 1'b0;
        set_rd(0, 29); set_rd(1, 5);
        push_rd(0, 32'h0000fffc, 1'b1, "rst_sp");
        push_rd(1, 32'h0, 1'b1, "rst_r5");
        push_cnt(6'd0, 1'b0, "rst_cnt");

        // Dirty some state
        step(); we0 = 1'b1; waddr0 = 5; wdata0 = 32'haaaa;
        we1 = 1'b1; waddr1 = 29; wdata1 = 32'h1234;
        pend_set = 1'b1; pend_addr = 12;
        set_rd(0, 5); set_rd(1, 29);
        push_rd(0, 32'haaaa, 1'b1, "dirty_fwd0");
        push_rd(1, 32'h1234, 1'b1, "dirty_fwd1");
        push_cnt(6'd0, 1'b0, "dirty_cnt0");

        step(); set_rd(0, 5); set_rd(1, 12);
        push_rd(0, 32'haaaa, 1'b1, "dirty_r5");
        push_rd(1, 32'h0, 1'b0, "dirty_pend12");
        push_cnt(6'd1, 1'b0, "dirty_cnt1");

        // Reset asserted mid-cycle with a write and a pending set in flight
        step(); we0 = 1'b1; waddr0 = 3; wdata0 = 32'h99;
        pend_set = 1'b1; pend_addr = 7;
        set_rd(0, 29); set_rd(1, 5);
        #2 reset = 1'b1;
        push_rd(0, 32'h0000fffc, 1'b1, "midrst_sp");
        push_rd(1, 32'h0, 1'b1, "midrst_r5");
        push_cnt(6'd0, 1'b0, "midrst_cnt");

        step(); reset = 1'b0;
        set_rd(0, 3); set_rd(1, 12);
        push_rd(0, 32'h0, 1'b1, "midrst_wr_dropped");
        push_rd(1, 32'h0, 1'b1, "midrst_pend_cleared");
        push_cnt(6'd0, 1'b0, "midrst_cnt2");

        step(); set_rd(0, 7);
        push_rd(0, 32'h0, 1'b1, "midrst_set_dropped");

        // Write priority and forwarding
        step(); we0 = 1'b1; waddr0 = 7; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 7; wdata1 = 32'h22;
        set_rd(0, 7); set_rd(1, 3);
        push_rd(0, 32'h22, 1'b1, "prio_fwd");
        push_rd(1, 32'h0, 1'b1, "prio_other");

        step(); set_rd(0, 7);
        push_rd(0, 32'h22, 1'b1, "prio_stored");

        // Enable-qualified forwarding
        step(); we1 = 1'b1; waddr1 = 3; wdata1 = 32'h5;
        set_rd(0, 3);
        push_rd(0, 32'h5, 1'b1, "r3_fwd");

        step(); waddr0 = 3; wdata0 = 32'hdead; waddr1 = 3; wdata1 = 32'hbeef;
        set_rd(0, 3);
        push_rd(0, 32'h5, 1'b1, "noen_nofwd");

        step(); we0 = 1'b1; waddr0 = 0; wdata0 = 32'hffff;
        set_rd(0, 0); set_rd(1, 3);
        push_rd(0, 32'h0, 1'b1, "r0_fwd_blocked");
        push_rd(1, 32'h5, 1'b1, "r3_held");

        step(); set_rd(0, 0);
        push_rd(0, 32'h0, 1'b1, "r0_zero");

        // Scoreboard set and clear by write
        step(); pend_set = 1'b1; pend_addr = 9;
        set_rd(0, 9);
        push_rd(0, 32'h0, 1'b1, "pend9_before");
        push_cnt(6'd0, 1'b0, "pend9_cnt0");

        step(); set_rd(0, 9);
        push_rd(0, 32'h0, 1'b0, "pend9_notready");
        push_cnt(6'd1, 1'b0, "pend9_cnt1");

        step(); we1 = 1'b1; waddr1 = 9; wdata1 = 32'h77;
        set_rd(0, 9);
        push_rd(0, 32'h77, 1'b1, "pend9_wb_fwd");
        push_cnt(6'd1, 1'b0, "pend9_cnt_wb");

        step(); set_rd(0, 9);
        push_rd(0, 32'h77, 1'b1, "pend9_after");
        push_cnt(6'd0, 1'b0, "pend9_cnt_clr");

        // Set wins over same-cycle write; flush wins over set
        step(); pend_set = 1'b1; pend_addr = 4;
        push_cnt(6'd0, 1'b0, "coll_cnt0");

        step(); pend_set = 1'b1; pend_addr = 4; we0 = 1'b1; waddr0 = 4; wdata0 = 32'h44;
        set_rd(0, 4);
        push_rd(0, 32'h44, 1'b1, "coll_fwd");
        push_cnt(6'd1, 1'b0, "coll_cnt1");

        step(); set_rd(0, 4);
        push_rd(0, 32'h44, 1'b0, "coll_still_pend");
        push_cnt(6'd1, 1'b0, "coll_cnt_same");

        step(); pend_set = 1'b1; pend_addr = 4; flush = 1'b1;
        push_cnt(6'd1, 1'b0, "flush_pre");

        step(); set_rd(0, 4);
        push_rd(0, 32'h44, 1'b1, "flush_r4_ready");
        push_cnt(6'd0, 1'b0, "flush_cnt0");

        // Count ramp to full
        for (int i = 1; i < 32; i++) begin
            step(); pend_set = 1'b1; pend_addr = 5'(i);
            push_cnt(6'(i - 1), 1'b0, "ramp_cnt");
        end

        step(); set_rd(0, 1); set_rd(1, 31);
        push_rd(0, 32'h0, 1'b0, "full_r1_pend");
        push_rd(1, 32'h0, 1'b0, "full_r31_pend");
        push_cnt(6'd31, 1'b1, "full_cnt31");

        step(); we0 = 1'b1; waddr0 = 10; wdata0 = 32'ha;
        we1 = 1'b1; waddr1 = 20; wdata1 = 32'hb;
        set_rd(0, 10); set_rd(1, 20);
        push_rd(0, 32'ha, 1'b1, "dual_fwd0");
        push_rd(1, 32'hb, 1'b1, "dual_fwd1");
        push_cnt(6'd31, 1'b1, "dual_cnt_pre");

        step(); set_rd(0, 10); set_rd(1, 11);
        push_rd(0, 32'ha, 1'b1, "dual_r10_clr");
        push_rd(1, 32'h0, 1'b0, "dual_r11_pend");
        push_cnt(6'd29, 1'b0, "dual_cnt29");

        // Both ports clearing the same pending register counts once
        step(); we0 = 1'b1; waddr0 = 21; wdata0 = 32'h1;
        we1 = 1'b1; waddr1 = 21; wdata1 = 32'h2;

        step(); set_rd(0, 21);
        push_rd(0, 32'h2, 1'b1, "same_idx_clr");
        push_cnt(6'd28, 1'b0, "same_idx_cnt28");

        // Re-setting a pending register and setting index 0 leave the count alone
        step(); pend_set = 1'b1; pend_addr = 22;
        step(); pend_set = 1'b1; pend_addr = 0;
        push_cnt(6'd28, 1'b0, "reset_pending_cnt");
        step(); set_rd(0, 0);
        push_rd(0, 32'h0, 1'b1, "set_r0_ready");
        push_cnt(6'd28, 1'b0, "set_r0_cnt");

        step(); flush = 1'b1;
        step(); set_rd(0, 22);
        push_rd(0, 32'h0, 1'b1, "final_flush_ready");
        push_cnt(6'd0, 1'b0, "final_flush_cnt");

        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL sb_drain: got %0d pending entries, want 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised successor of the single-write 32x32 register file, for the pipelined/multi-issue CPU. It adds configurable width, depth and read-port count, and two write ports with fixed priority. Write-through forwarding is qualified by write enables. A per-register pending scoreboard lets the decode stage detect results still in flight from multi-cycle units such as loads and mul/div.

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W, and entry 0 is hardwired to zero
NREAD, 2, number of independent combinational read ports
SP_IDX, 29, index of the register that resets to SP_INIT
SP_INIT, 32'h0000fffc, reset value of register SP_IDX (truncated/zero-extended to DATA_W)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
rd_addr  input  NREAD*ADDR_W  read indices; port i occupies bits [i*ADDR_W +: ADDR_W]
rd_data  output  NREAD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W]
rd_ready  output  NREAD  1 = rd_data for port i is architecturally valid (not pending)
we0  input  1  write enable, port 0 (ALU writeback)
waddr0  input  ADDR_W  write index, port 0
wdata0  input  DATA_W  write data, port 0
we1  input  1  write enable, port 1 (memory/long-latency writeback); higher priority
waddr1  input  ADDR_W  write index, port 1
wdata1  input  DATA_W  write data, port 1
pend_set  input  1  mark register pend_addr as pending (issue of a long-latency op)
pend_addr  input  ADDR_W  register to mark pending
flush  input  1  synchronous clear of all pending bits
pend_cnt  output  ADDR_W+1  number of registers currently pending
pend_full  output  1  1 when pend_cnt == 2**ADDR_W - 1

Behaviour:
- Reset (async, active-high): all registers = 0, except register SP_IDX = SP_INIT. All pending bits = 0, pend_cnt = 0. Reset takes effect immediately and overrides every input; reset asserted mid-operation discards in-flight writes and pending sets.
- Effective write for port k: wek && waddrk != 0. Writes to index 0 are ignored. Port 0 keeps its effect on pending bits only if it is itself effective.
- Write commit on rising clk. If both ports are effective and target the same index, wdata1 is stored. Different indices are both stored.
- Read port i is fully combinational:
  - rd_addr_i == 0 → 0.
  - Else, effective port 1 write to the same index → wdata1.
  - Else, effective port 0 write to the same index → wdata0.
  - Else → stored value.
  - Forwarding never occurs when the enable is low. This is a fix: the previous block forwarded on address match alone.
- rd_ready_i:
  - 1 if rd_addr_i == 0.
  - Else 1 if an effective write to that index occurs this cycle.
  - Else the inverse of the pending bit.
- Pending bit update per index r on rising clk, in priority order:
  - flush=1 → bit 0. flush overrides pend_set in the same cycle.
  - Else pend_set && pend_addr==r && r!=0 → bit 1. Set wins over a same-cycle write to r: the write data is stored, but the new producer is outstanding.
  - Else an effective write to r → bit 0.
  - Else hold.
  - pend_set to index 0 is ignored.
- pend_cnt is a registered counter kept equal to the popcount of the pending bits after every edge. Net change per cycle = (sets of a non-pending reg) − (clears of pending regs). The range is -2..+1.
  - flush sets it to 0.
  - Setting an already-pending bit leaves the count unchanged.
  - Clearing a non-pending bit leaves the count unchanged.
- pend_full is combinational from pend_cnt.
- Latency: a write is visible on reads in the same cycle via forwarding, and from storage in the next cycle.

Test Plan:
- Reset: assert reset mid-cycle with registers dirty → rd_data for index 29 = 0x0000fffc, index 5 = 0; pend_cnt = 0; all rd_ready = 1.
- Priority/forward: we0=we1=1, waddr0=waddr1=7, wdata0=0x11, wdata1=0x22 → same cycle rd_data(7)=0x22; next cycle rd_data(7)=0x22 with both write enables low.
- Enable-qualified forward: we0=0, waddr0=3, wdata0=0xdead, reg3 = 0x5 → rd_data(3)=0x5. Also we0=1, waddr0=0, wdata0=0xffff → rd_data(0)=0 and register 0 is never written.
- Scoreboard: pend_set on reg 9 → next cycle rd_ready(9)=0, pend_cnt=1. In the cycle we1 writes reg 9 = 0x77, rd_ready(9)=1 and rd_data=0x77; afterwards pend_cnt=0.
- Set-vs-clear collision: reg 4 is pending; pend_set(4) and we0 write to 4 in the same cycle → data stored, bit stays 1, pend_cnt unchanged. pend_set(4) with flush → pend_cnt=0.
- Count boundaries: pend_set on indices 1..31, one per cycle → pend_cnt=31, pend_full=1. Then two writes to distinct pending regs in one cycle → pend_cnt=29, pend_full=0.
